// File: rtl/shift_pkg.sv
// Shared encodings for the pipelined shift/rotate unit.
package shift_pkg;

  localparam int unsigned MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_ROL = 3'b000;
  localparam mode_t MODE_ROR = 3'b001;
  localparam mode_t MODE_SLL = 3'b010;
  localparam mode_t MODE_SRL = 3'b011;
  localparam mode_t MODE_SRA = 3'b100;

endpackage

// File: rtl/shift_rotate_pipe_if.sv
// Operation/result handshake bundle for shift_rotate_pipe.
interface shift_rotate_pipe_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) ();
  import shift_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_cnt;
  mode_t            in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;

  // Producer/consumer side (operand muxes and writeback).
  modport master (
    output in_valid, in_data, in_cnt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero
  );

  // Shift unit side.
  modport slave (
    input  in_valid, in_data, in_cnt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero
  );

endinterface

// File: rtl/shift_stage.sv
// One registered level of the shifter: shifts by STEP when its count bit is set.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [CNT_W-1:0] i_cnt,
  input  mode_t            i_mode,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_down_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt,
  output mode_t            o_mode,
  output logic [TAG_W-1:0] o_tag
);

  localparam int unsigned BIT = $clog2(STEP);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  mode_t            r_mode;
  logic [TAG_W-1:0] r_tag;

  logic             w_ready;
  logic             w_load;
  logic [WIDTH-1:0] w_shifted;

  // Shift mux; the MSB is untouched by every earlier SRA step, so it still holds the sign.
  always_comb begin
    w_shifted = i_data;
    if (i_cnt[BIT]) begin
      case (i_mode)
        MODE_ROL: w_shifted = (i_data << STEP) | (i_data >> (WIDTH - STEP));
        MODE_ROR: w_shifted = (i_data >> STEP) | (i_data << (WIDTH - STEP));
        MODE_SLL: w_shifted = i_data << STEP;
        MODE_SRL: w_shifted = i_data >> STEP;
        MODE_SRA: w_shifted = $signed(i_data) >>> STEP;
        default:  w_shifted = i_data;
      endcase
    end
  end

  assign w_ready = !r_valid || i_down_ready;
  assign w_load  = i_valid && w_ready;

  // Stage registers: valid follows upstream when ready, fields only move on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_tag   <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_ready) begin
        r_valid <= i_valid;
      end
      if (w_load) begin
        r_data <= w_shifted;
        r_cnt  <= i_cnt;
        r_mode <= i_mode;
        r_tag  <= i_tag;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;
  assign o_mode  = r_mode;
  assign o_tag   = r_tag;

endmodule

// File: rtl/shift_rotate_pipe.sv
// Pipelined shift/rotate unit: CNT_W registered stages, stage k shifts by 2^k.
module shift_rotate_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  shift_rotate_pipe_if.slave  bus,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  // Index k is the input of stage k; index CNT_W is the last stage's output.
  logic             w_valid [CNT_W+1];
  logic [WIDTH-1:0] w_data  [CNT_W+1];
  logic [CNT_W-1:0] w_cnt   [CNT_W+1];
  mode_t            w_mode  [CNT_W+1];
  logic [TAG_W-1:0] w_tag   [CNT_W+1];

  logic [CNT_W-1:0] w_stage_valid;
  logic             w_unused;

  assign w_valid[0] = bus.in_valid;
  assign w_data[0]  = bus.in_data;
  assign w_cnt[0]   = bus.in_cnt;
  assign w_mode[0]  = bus.in_mode;
  assign w_tag[0]   = bus.in_tag;

  for (genvar k = 0; k < CNT_W; k++) begin : g_stage
    logic w_down_ready;

    assign w_stage_valid[k] = w_valid[k+1];

    // Ready chain !valid_k | ready_k+1 unrolled: a downstream stage is ready if any
    // stage between it and the output is empty, or the consumer takes the result.
    if (k == CNT_W - 1) begin : g_last
      assign w_down_ready = bus.out_ready;
    end else begin : g_mid
      assign w_down_ready = bus.out_ready || !(&w_stage_valid[CNT_W-1:k+1]);
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .CNT_W (CNT_W),
      .STEP  (1 << k)
    ) u_stage (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (flush),
      .i_valid      (w_valid[k]),
      .i_data       (w_data[k]),
      .i_cnt        (w_cnt[k]),
      .i_mode       (w_mode[k]),
      .i_tag        (w_tag[k]),
      .i_down_ready (w_down_ready),
      .o_valid      (w_valid[k+1]),
      .o_data       (w_data[k+1]),
      .o_cnt        (w_cnt[k+1]),
      .o_mode       (w_mode[k+1]),
      .o_tag        (w_tag[k+1])
    );
  end

  assign bus.in_ready  = bus.out_ready || !(&w_stage_valid);
  assign bus.out_valid = w_valid[CNT_W];
  assign bus.out_data  = w_data[CNT_W];
  assign bus.out_tag   = w_tag[CNT_W];
  assign bus.out_zero  = (w_data[CNT_W] == '0);
  assign busy          = |w_stage_valid;

  // Count and mode leaving the final stage have no consumer.
  assign w_unused = ^{w_cnt[CNT_W], w_mode[CNT_W]};

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Directed self-checking bench for shift_rotate_pipe (WIDTH=16, TAG_W=4).
module tb_shift_rotate_pipe;
  import shift_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned TAG_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  int n_total = 0;
  int n_bad   = 0;

  shift_rotate_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  shift_rotate_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] c,
                       input logic [2:0] m, input logic [3:0] t);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_cnt   = c;
    bus.in_mode  = m;
    bus.in_tag   = t;
  endtask

  // One isolated op with out_ready=1: checks latency, result, tag and zero flag.
  task automatic single(input string name, input logic [15:0] d, input logic [3:0] c,
                        input logic [2:0] m, input logic [3:0] t, input logic [15:0] exp,
                        input logic exp_zero);
    int lat;
    drive(1'b1, d, c, m, t);
    #1;
    check({name, "_rdy"}, 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b0, 16'h0, 4'h0, 3'h0, 4'h0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'd4);
    check({name, "_data"}, 32'(bus.out_data), 32'(exp));
    check({name, "_tag"}, 32'(bus.out_tag), 32'(t));
    check({name, "_zero"}, 32'(bus.out_zero), 32'(exp_zero));
    step();
    check({name, "_pop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int j;
    int idx;
    int seen;
    logic rdy;
    logic [15:0] d;

    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 16'h0, 4'h0, 3'h0, 4'h0);
    #3;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_tag", 32'(bus.out_tag), 32'd0);
    check("rst_zero", 32'(bus.out_zero), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_inrdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single operations, expected values computed by hand.
    single("rol",  16'h8001, 4'd1,  MODE_ROL, 4'hA, 16'h0003, 1'b0);
    single("ror",  16'h0001, 4'd1,  MODE_ROR, 4'h1, 16'h8000, 1'b0);
    single("sra",  16'h8000, 4'd15, MODE_SRA, 4'h2, 16'hFFFF, 1'b0);
    single("srl",  16'h8000, 4'd15, MODE_SRL, 4'h3, 16'h0001, 1'b0);
    single("sll4", 16'hFFFF, 4'd4,  MODE_SLL, 4'h4, 16'hFFF0, 1'b0);
    single("sll0", 16'h0001, 4'd0,  MODE_SLL, 4'h5, 16'h0001, 1'b0);
    single("rsv",  16'h1234, 4'd5,  3'b111,   4'h6, 16'h1234, 1'b0);
    single("sraP", 16'h7F00, 4'd4,  MODE_SRA, 4'h7, 16'h07F0, 1'b0);
    single("rol4", 16'h1234, 4'd4,  MODE_ROL, 4'h8, 16'h2341, 1'b0);
    single("ror8", 16'h1234, 4'd8,  MODE_ROR, 4'h9, 16'h3412, 1'b0);
    single("msb",  16'h0001, 4'd15, MODE_SLL, 4'hB, 16'h8000, 1'b0);
    single("zero", 16'h0002, 4'd15, MODE_SLL, 4'hC, 16'h0000, 1'b1);

    // Back-to-back: op i is SLL by 1 of 16'h1111*i, result 16'h2222*i, tag i.
    for (int t = 0; t < 13; t++) begin
      if (t >= 4 && t <= 11) begin
        check("b2b_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_tag", 32'(bus.out_tag), 32'(t - 4));
        d = 16'(16'h2222 * (t - 4));
        check("b2b_data", 32'(bus.out_data), 32'(d));
      end else begin
        check("b2b_idle", 32'(bus.out_valid), 32'd0);
      end
      if (t < 8) begin
        d = 16'(16'h1111 * t);
        drive(1'b1, d, 4'd1, MODE_SLL, 4'(t));
      end else begin
        drive(1'b0, 16'h0, 4'h0, 3'h0, 4'h0);
      end
      #1;
      if (t < 8) check("b2b_inrdy", 32'(bus.in_ready), 32'd1);
      step();
    end

    // Backpressure: op j is ROR by 4 of 16'h00F0|j, result (j<<12)|16'h000F, tag 8+j.
    bus.out_ready = 1'b0;
    j = 0;
    for (int t = 0; t < 6; t++) begin
      drive(1'b1, 16'h00F0 | 16'(j), 4'd4, MODE_ROR, 4'(8 + j));
      #1;
      rdy = bus.in_ready;
      step();
      if (rdy) j++;
    end
    check("bp_accepted", 32'(j), 32'd4);
    check("bp_inrdy", 32'(bus.in_ready), 32'd0);
    for (int t = 0; t < 3; t++) begin
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_data", 32'(bus.out_data), 32'h000F);
      check("bp_hold_tag", 32'(bus.out_tag), 32'd8);
      step();
    end
    bus.out_ready = 1'b1;
    idx = 0;
    for (int t = 0; t < 30 && idx < 6; t++) begin
      if (bus.out_valid) begin
        check("bp_tag", 32'(bus.out_tag), 32'(8 + idx));
        d = 16'(idx << 12) | 16'h000F;
        check("bp_data", 32'(bus.out_data), 32'(d));
        idx++;
      end
      if (j < 6) drive(1'b1, 16'h00F0 | 16'(j), 4'd4, MODE_ROR, 4'(8 + j));
      else drive(1'b0, 16'h0, 4'h0, 3'h0, 4'h0);
      #1;
      rdy = bus.in_ready && bus.in_valid;
      step();
      if (rdy) j++;
    end
    check("bp_count", 32'(idx), 32'd6);
    check("bp_empty", 32'(bus.out_valid), 32'd0);
    check("bp_busy", 32'(busy), 32'd0);

    // Asynchronous reset with three ops in flight.
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, 16'hABCD, 4'd3, MODE_ROL, 4'(1 + t));
      step();
    end
    drive(1'b0, 16'h0, 4'h0, 3'h0, 4'h0);
    check("ar_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(bus.out_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_data", 32'(bus.out_data), 32'd0);
    check("ar_tag", 32'(bus.out_tag), 32'd0);
    check("ar_zero", 32'(bus.out_zero), 32'd1);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (bus.out_valid) seen++;
    end
    check("ar_no_result", 32'(seen), 32'd0);

    // Flush with two ops in flight plus a third offered in the flush cycle.
    for (int t = 0; t < 2; t++) begin
      drive(1'b1, 16'h5555, 4'd2, MODE_SLL, 4'(3 + t));
      step();
    end
    drive(1'b1, 16'h6666, 4'd2, MODE_SLL, 4'h5);
    flush = 1'b1;
    #1;
    check("fl_inrdy", 32'(bus.in_ready), 32'd1);
    step();
    flush = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 3'h0, 4'h0);
    check("fl_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (bus.out_valid) seen++;
    end
    check("fl_no_result", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
